// File: rtl/cr_xp10_decomp_htf_histogram_pp_pkg.sv
// Shared types and helpers for the XP10 decompressor Huffman-table histogram.
// Holds the fill/drain state encodings and the saturating counter add.
package cr_xp10_decomp_htf_histogram_pp_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ACC  = 2'd1,
    F_WAIT = 2'd2
  } fill_state_e;

  typedef enum logic {
    D_IDLE   = 1'b0,
    D_STREAM = 1'b1
  } drain_state_e;

  // Returns min(base + inc, max_val); callers slice the result to their counter width.
  function automatic logic [31:0] sat_add(input logic [31:0] base,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum_v;
    sum_v = {1'b0, base} + {1'b0, inc};
    if (sum_v > {1'b0, max_val}) begin
      sat_add = max_val;
    end else begin
      sat_add = sum_v[31:0];
    end
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_htf_hist_bank.sv
// One histogram bank: DEPTH saturating counters fed by several increment lanes,
// with a sticky saturation flag, a running total of the clipped counts and a read mux.
module cr_xp10_decomp_htf_hist_bank
  import cr_xp10_decomp_htf_histogram_pp_pkg::*;
#(
  parameter int DEPTH         = 27,
  parameter int WIDTH         = 10,
  parameter int NUM_INC_PORTS = 2,
  parameter int TOTAL_W       = WIDTH + $clog2(DEPTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear,
  input  logic [NUM_INC_PORTS-1:0]                 lane_vld,
  input  logic [NUM_INC_PORTS*$clog2(DEPTH+1)-1:0] lane_addr,
  input  logic [$clog2(DEPTH+1)-1:0]               rd_addr,
  output logic [WIDTH-1:0]                         rd_count,
  output logic [TOTAL_W-1:0]                       total,
  output logic                                     sat
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(NUM_INC_PORTS + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0]   cnt_r     [DEPTH];
  logic [WIDTH-1:0]   cnt_nxt_s [DEPTH];
  logic [TOTAL_W-1:0] total_r;
  logic [TOTAL_W-1:0] total_nxt_s;
  logic               sat_r;
  logic               sat_nxt_s;

  // Per-symbol lane hit count, saturating update, total and sticky sat next-state
  always_comb begin
    logic [CW-1:0]    hits_v;
    logic [WIDTH-1:0] base_v;
    logic [31:0]      sum_v;
    logic             clip_v;
    hits_v      = '0;
    base_v      = '0;
    sum_v       = '0;
    clip_v      = 1'b0;
    total_nxt_s = clear ? '0 : total_r;
    sat_nxt_s   = clear ? 1'b0 : sat_r;
    for (int s = 0; s < DEPTH; s++) begin
      hits_v = '0;
      for (int l = 0; l < NUM_INC_PORTS; l++) begin
        hits_v = (lane_vld[l] && (lane_addr[l*AW +: AW] == AW'(s + 1))) ? hits_v + CW'(1) : hits_v;
      end
      base_v       = clear ? '0 : cnt_r[s];
      sum_v        = sat_add(32'(base_v), 32'(hits_v), 32'(CNT_MAX));
      clip_v       = (32'(base_v) + 32'(hits_v)) > 32'(CNT_MAX);
      cnt_nxt_s[s] = sum_v[WIDTH-1:0];
      // Total tracks what was actually stored, so clipped amounts never reach it
      total_nxt_s  = total_nxt_s + TOTAL_W'(cnt_nxt_s[s] - base_v);
      sat_nxt_s    = sat_nxt_s | clip_v;
    end
  end

  // Counter, total and sat state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        cnt_r[s] <= '0;
      end
      total_r <= '0;
      sat_r   <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        cnt_r[s] <= cnt_nxt_s[s];
      end
      total_r <= total_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

  // Read mux by 1-based symbol index; index 0 reads as zero
  always_comb begin
    rd_count = '0;
    for (int s = 0; s < DEPTH; s++) begin
      rd_count = (rd_addr == AW'(s + 1)) ? cnt_r[s] : rd_count;
    end
  end

  assign total = total_r;
  assign sat   = sat_r;

endmodule

// File: rtl/cr_xp10_decomp_htf_histogram_pp_chk.sv
// Protocol checks for the ping-pong histogram: dropped fill-side events,
// over-range lane counts, and drain outputs holding steady under backpressure.
module cr_xp10_decomp_htf_histogram_pp_chk #(
  parameter int AW      = 5,
  parameter int CW      = 2,
  parameter int WIDTH   = 10,
  parameter int TOTAL_W = 15,
  parameter int NUM_INC_PORTS = 2
) (
  input logic               clk,
  input logic               rst,
  input logic               fill_ready,
  input logic               hist_start,
  input logic               hist_done,
  input logic [CW-1:0]      hist_inc,
  input logic               rd_valid,
  input logic               rd_ready,
  input logic [AW-1:0]      rd_sym,
  input logic [WIDTH-1:0]   rd_count,
  input logic [TOTAL_W-1:0] rd_total,
  input logic               rd_sat
);

  a_no_fill_when_busy: assert property (@(posedge clk) disable iff (rst)
    !fill_ready |-> !(hist_start || hist_done || (hist_inc != '0)))
    else $error("fill-side event dropped while fill_ready is low");

  a_inc_in_range: assert property (@(posedge clk) disable iff (rst)
    hist_inc <= CW'(NUM_INC_PORTS))
    else $error("hist_inc exceeds lane count, clamped");

  a_no_start_with_done: assert property (@(posedge clk) disable iff (rst)
    !(hist_start && hist_done && fill_ready))
    else $error("hist_start dropped in favour of hist_done");

  a_drain_stable: assert property (@(posedge clk) disable iff (rst)
    (rd_valid && !rd_ready) |=> (rd_valid && $stable(rd_sym) && $stable(rd_count)
                                 && $stable(rd_total) && $stable(rd_sat)))
    else $error("drain outputs changed while stalled");

endmodule

// File: rtl/cr_xp10_decomp_htf_histogram_pp.sv
// Ping-pong symbol histogram: one bank accumulates multi-lane increments while
// the other streams its finished counts to the code-length builder.
module cr_xp10_decomp_htf_histogram_pp
  import cr_xp10_decomp_htf_histogram_pp_pkg::*;
#(
  parameter int DEPTH         = 27,
  parameter int WIDTH         = 10,
  parameter int NUM_INC_PORTS = 2,
  parameter int TOTAL_W       = WIDTH + $clog2(DEPTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     hist_start,
  input  logic [NUM_INC_PORTS*$clog2(DEPTH+1)-1:0] hist_waddr,
  input  logic [$clog2(NUM_INC_PORTS+1)-1:0]       hist_inc,
  input  logic                                     hist_done,
  output logic                                     fill_ready,
  output logic                                     rd_valid,
  input  logic                                     rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]               rd_sym,
  output logic [WIDTH-1:0]                         rd_count,
  output logic                                     rd_last,
  output logic [TOTAL_W-1:0]                       rd_total,
  output logic                                     rd_sat
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(NUM_INC_PORTS + 1);

  fill_state_e        fill_state_r, fill_state_nxt_s;
  drain_state_e       drain_state_r, drain_state_nxt_s;
  logic               fill_sel_r, fill_sel_nxt_s;
  logic               launch_r, launch_nxt_s;
  logic [AW-1:0]      rd_sym_r, rd_sym_nxt_s;

  logic               fill_ready_s, start_acc_s, done_acc_s, inc_en_s;
  logic [CW-1:0]      inc_n_s;
  logic [NUM_INC_PORTS-1:0] lane_vld_s, bank0_vld_s, bank1_vld_s;
  logic               hs_s, last_hs_s, drain_free_s, handoff_s, swap_now_s, swap_late_s;
  logic [WIDTH-1:0]   bank0_count_s, bank1_count_s;
  logic [TOTAL_W-1:0] bank0_total_s, bank1_total_s;
  logic               bank0_sat_s, bank1_sat_s;

  // Fill-side event qualification and lane steering into the fill bank
  always_comb begin
    fill_ready_s = (fill_state_r != F_WAIT);
    start_acc_s  = hist_start && !hist_done && fill_ready_s;
    done_acc_s   = hist_done && (fill_state_r == F_ACC);
    inc_en_s     = (fill_state_r == F_ACC) || start_acc_s;
    inc_n_s      = (hist_inc > CW'(NUM_INC_PORTS)) ? CW'(NUM_INC_PORTS) : hist_inc;
    for (int l = 0; l < NUM_INC_PORTS; l++) begin
      lane_vld_s[l] = inc_en_s && (CW'(l) < inc_n_s) && (hist_waddr[l*AW +: AW] != '0);
    end
    bank0_vld_s = fill_sel_r ? '0 : lane_vld_s;
    bank1_vld_s = fill_sel_r ? lane_vld_s : '0;
  end

  // Handoff decode: swap now if the drain is idle, or arm a delayed launch on its final handshake
  always_comb begin
    hs_s         = (drain_state_r == D_STREAM) && rd_ready;
    last_hs_s    = hs_s && (rd_sym_r == AW'(DEPTH));
    drain_free_s = (drain_state_r == D_IDLE) && !launch_r;
    handoff_s    = done_acc_s || (fill_state_r == F_WAIT);
    swap_now_s   = handoff_s && drain_free_s;
    swap_late_s  = handoff_s && last_hs_s;
  end

  // Fill FSM next state and bank select
  always_comb begin
    fill_state_nxt_s = fill_state_r;
    fill_sel_nxt_s   = fill_sel_r ^ (swap_now_s || swap_late_s);
    case (fill_state_r)
      F_IDLE:  fill_state_nxt_s = start_acc_s ? F_ACC : F_IDLE;
      F_ACC:   fill_state_nxt_s = done_acc_s ? ((swap_now_s || swap_late_s) ? F_IDLE : F_WAIT) : F_ACC;
      F_WAIT:  fill_state_nxt_s = (swap_now_s || swap_late_s) ? F_IDLE : F_WAIT;
      default: fill_state_nxt_s = F_IDLE;
    endcase
  end

  // Drain FSM next state and symbol walk
  always_comb begin
    drain_state_nxt_s = drain_state_r;
    rd_sym_nxt_s      = rd_sym_r;
    launch_nxt_s      = launch_r;
    case (drain_state_r)
      D_IDLE: begin
        if (swap_now_s || launch_r) begin
          drain_state_nxt_s = D_STREAM;
          launch_nxt_s      = 1'b0;
        end else begin
          drain_state_nxt_s = D_IDLE;
        end
      end
      D_STREAM: begin
        if (last_hs_s) begin
          drain_state_nxt_s = D_IDLE;
          rd_sym_nxt_s      = AW'(1);
          launch_nxt_s      = swap_late_s;
        end else if (hs_s) begin
          rd_sym_nxt_s = rd_sym_r + AW'(1);
        end else begin
          rd_sym_nxt_s = rd_sym_r;
        end
      end
      default: begin
        drain_state_nxt_s = D_IDLE;
        rd_sym_nxt_s      = AW'(1);
        launch_nxt_s      = 1'b0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_state_r  <= F_IDLE;
      drain_state_r <= D_IDLE;
      fill_sel_r    <= 1'b0;
      launch_r      <= 1'b0;
      rd_sym_r      <= AW'(1);
    end else begin
      fill_state_r  <= fill_state_nxt_s;
      drain_state_r <= drain_state_nxt_s;
      fill_sel_r    <= fill_sel_nxt_s;
      launch_r      <= launch_nxt_s;
      rd_sym_r      <= rd_sym_nxt_s;
    end
  end

  cr_xp10_decomp_htf_hist_bank #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_INC_PORTS(NUM_INC_PORTS), .TOTAL_W(TOTAL_W)
  ) u_bank0 (
    .clk(clk), .rst(rst), .clear(start_acc_s && !fill_sel_r),
    .lane_vld(bank0_vld_s), .lane_addr(hist_waddr), .rd_addr(rd_sym_r),
    .rd_count(bank0_count_s), .total(bank0_total_s), .sat(bank0_sat_s)
  );

  cr_xp10_decomp_htf_hist_bank #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_INC_PORTS(NUM_INC_PORTS), .TOTAL_W(TOTAL_W)
  ) u_bank1 (
    .clk(clk), .rst(rst), .clear(start_acc_s && fill_sel_r),
    .lane_vld(bank1_vld_s), .lane_addr(hist_waddr), .rd_addr(rd_sym_r),
    .rd_count(bank1_count_s), .total(bank1_total_s), .sat(bank1_sat_s)
  );

  // Drain outputs come from the bank not selected for filling
  always_comb begin
    fill_ready = fill_ready_s;
    rd_valid   = (drain_state_r == D_STREAM);
    rd_last    = (drain_state_r == D_STREAM) && (rd_sym_r == AW'(DEPTH));
    rd_sym     = rd_sym_r;
    rd_count   = fill_sel_r ? bank0_count_s : bank1_count_s;
    rd_total   = fill_sel_r ? bank0_total_s : bank1_total_s;
    rd_sat     = fill_sel_r ? bank0_sat_s   : bank1_sat_s;
  end

  cr_xp10_decomp_htf_histogram_pp_chk #(
    .AW(AW), .CW(CW), .WIDTH(WIDTH), .TOTAL_W(TOTAL_W), .NUM_INC_PORTS(NUM_INC_PORTS)
  ) u_chk (
    .clk(clk), .rst(rst), .fill_ready(fill_ready), .hist_start(hist_start),
    .hist_done(hist_done), .hist_inc(hist_inc), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_sym(rd_sym), .rd_count(rd_count), .rd_total(rd_total), .rd_sat(rd_sat)
  );

endmodule

// File: tb/tb_cr_xp10_decomp_htf_histogram_pp.sv
// Self-checking bench: random and directed histogram blocks against a counting model,
// plus a WIDTH=4 instance for saturation.
module tb_cr_xp10_decomp_htf_histogram_pp;

  localparam int DEPTH = 27;
  localparam int WIDTH = 10;
  localparam int NP    = 2;
  localparam int AW    = 5;
  localparam int CW    = 2;
  localparam int TW    = WIDTH + AW;
  localparam int MAXC  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, hist_start, hist_done, rd_ready;
  logic [NP*AW-1:0]  hist_waddr;
  logic [CW-1:0]     hist_inc;
  logic              fill_ready, rd_valid, rd_last, rd_sat;
  logic [AW-1:0]     rd_sym;
  logic [WIDTH-1:0]  rd_count;
  logic [TW-1:0]     rd_total;

  logic              s4_start, s4_done, s4_fill_ready, s4_rd_valid, s4_rd_ready, s4_rd_last, s4_rd_sat;
  logic [NP*AW-1:0]  s4_waddr;
  logic [CW-1:0]     s4_inc;
  logic [AW-1:0]     s4_rd_sym;
  logic [3:0]        s4_rd_count;
  logic [4+AW-1:0]   s4_rd_total;

  cr_xp10_decomp_htf_histogram_pp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_INC_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .hist_start(hist_start), .hist_waddr(hist_waddr), .hist_inc(hist_inc),
    .hist_done(hist_done), .fill_ready(fill_ready), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_sym(rd_sym), .rd_count(rd_count), .rd_last(rd_last), .rd_total(rd_total), .rd_sat(rd_sat));

  cr_xp10_decomp_htf_histogram_pp #(.DEPTH(DEPTH), .WIDTH(4), .NUM_INC_PORTS(NP)) dut_w4 (
    .clk(clk), .rst(rst), .hist_start(s4_start), .hist_waddr(s4_waddr), .hist_inc(s4_inc),
    .hist_done(s4_done), .fill_ready(s4_fill_ready), .rd_valid(s4_rd_valid), .rd_ready(s4_rd_ready),
    .rd_sym(s4_rd_sym), .rd_count(s4_rd_count), .rd_last(s4_rd_last), .rd_total(s4_rd_total),
    .rd_sat(s4_rd_sat));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: plain per-symbol counts, one block at a time
  int m_cnt [1:DEPTH];
  bit m_sat, m_acc;
  int exp_cnt_q [$];
  int exp_tot_q [$];
  bit exp_sat_q [$];

  task automatic model_clear();
    for (int s = 1; s <= DEPTH; s++) m_cnt[s] = 0;
    m_sat = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one fill-side cycle and apply the same event to the model
  task automatic drive(input bit st, input bit dn, input int n, input int a0, input int a1);
    int addr [2];
    int tot;
    hist_start = st;
    hist_done  = dn;
    hist_inc   = CW'(n);
    hist_waddr = {AW'(a1), AW'(a0)};
    addr[0] = a0;
    addr[1] = a1;
    if (st && !dn) begin
      model_clear();
      m_acc = 1'b1;
    end
    if (m_acc) begin
      for (int l = 0; l < n && l < NP; l++) begin
        if (addr[l] != 0) begin
          if (m_cnt[addr[l]] == MAXC) m_sat = 1'b1;
          else m_cnt[addr[l]]++;
        end
      end
    end
    if (dn && m_acc) begin
      tot = 0;
      for (int s = 1; s <= DEPTH; s++) begin
        exp_cnt_q.push_back(m_cnt[s]);
        tot += m_cnt[s];
      end
      exp_tot_q.push_back(tot);
      exp_sat_q.push_back(m_sat);
      m_acc = 1'b0;
    end
    step();
    hist_start = 1'b0;
    hist_done  = 1'b0;
    hist_inc   = '0;
    hist_waddr = '0;
  endtask

  task automatic rand_incs(input int k);
    for (int i = 0; i < k; i++)
      drive(1'b0, 1'b0, $urandom_range(2, 0), $urandom_range(DEPTH, 0), $urandom_range(DEPTH, 0));
  endtask

  task automatic wait_fill_ready();
    for (int i = 0; i < 500 && !fill_ready; i++) step();
    check_eq("fill_ready_wait", fill_ready, 1);
  endtask

  task automatic wait_drain_empty();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_tot_q.size() == 0 && !rd_valid) break;
    end
    check_eq("drain_complete", exp_tot_q.size(), 0);
    step();
  endtask

  int rdy_pct = 100;
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_ready = ($urandom_range(99, 0) < rdy_pct);
    end
  end

  // Drain monitor: compares every accepted entry with the head expected block
  int exp_sym    = 1;
  int last_hs    = -100;
  bit gap_armed  = 1'b0;
  bit prev_valid = 1'b0;
  int seen_cnt [1:DEPTH];
  int seen_total;
  bit seen_sat;
  initial begin
    int dummy;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt_q.delete();
        exp_tot_q.delete();
        exp_sat_q.delete();
        exp_sym    = 1;
        prev_valid = 1'b0;
      end else begin
        if (rd_valid && !prev_valid && gap_armed) begin
          check_eq("handoff_gap", cyc - last_hs, 2);
          gap_armed = 1'b0;
        end
        prev_valid = rd_valid;
        if (rd_valid && rd_ready) begin
          if (exp_tot_q.size() == 0) begin
            check_eq("unexpected_entry", exp_tot_q.size(), 1);
          end else begin
            check_eq("rd_sym", rd_sym, exp_sym);
            check_eq("rd_count", rd_count, exp_cnt_q[exp_sym-1]);
            check_eq("rd_total", rd_total, exp_tot_q[0]);
            check_eq("rd_sat", rd_sat, exp_sat_q[0]);
            check_eq("rd_last", rd_last, exp_sym == DEPTH);
            seen_cnt[exp_sym] = rd_count;
            if (exp_sym == DEPTH) begin
              seen_total = rd_total;
              seen_sat   = rd_sat;
              last_hs    = cyc;
              for (int s = 0; s < DEPTH; s++) dummy = exp_cnt_q.pop_front();
              dummy = exp_tot_q.pop_front();
              dummy = int'(exp_sat_q.pop_front());
              exp_sym = 1;
            end else begin
              exp_sym++;
            end
          end
        end
      end
    end
  end

  initial begin
    int t0;
    int s4_cnt [1:DEPTH];
    int s4_tot;
    bit s4_sat_seen;
    rst = 1'b1;
    hist_start = 1'b0; hist_done = 1'b0; hist_inc = '0; hist_waddr = '0;
    s4_start = 1'b0; s4_done = 1'b0; s4_inc = '0; s4_waddr = '0; s4_rd_ready = 1'b1;
    m_acc = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_fill_ready", fill_ready, 1);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_last", rd_last, 0);
    check_eq("rst_rd_sat", rd_sat, 0);
    check_eq("rst_rd_sym", rd_sym, 1);
    check_eq("rst_rd_count", rd_count, 0);
    check_eq("rst_rd_total", rd_total, 0);
    step();

    // Directed block: {3,3} x4 then {5,0}
    drive(1'b1, 1'b0, 0, 0, 0);
    repeat (4) drive(1'b0, 1'b0, 2, 3, 3);
    drive(1'b0, 1'b0, 2, 5, 0);
    drive(1'b0, 1'b1, 0, 0, 0);
    @(negedge clk);
    check_eq("swap_rd_valid", rd_valid, 1);
    check_eq("swap_rd_sym", rd_sym, 1);
    t0 = cyc;
    wait_drain_empty();
    check_eq("blk1_sym3", seen_cnt[3], 8);
    check_eq("blk1_sym5", seen_cnt[5], 1);
    check_eq("blk1_sym4", seen_cnt[4], 0);
    check_eq("blk1_total", seen_total, 9);
    check_eq("blk1_sat", seen_sat, 0);
    check_eq("drain_cycles", last_hs - t0, DEPTH - 1);

    // Saturation on the 4-bit instance: 20 increments of symbol 7
    s4_start = 1'b1;
    step();
    s4_start = 1'b0;
    s4_inc   = 2'd2;
    s4_waddr = {5'd7, 5'd7};
    repeat (10) step();
    s4_inc   = '0;
    s4_waddr = '0;
    s4_done  = 1'b1;
    step();
    s4_done  = 1'b0;
    s4_tot = -1;
    s4_sat_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s4_rd_valid && s4_rd_ready) begin
        s4_cnt[s4_rd_sym] = s4_rd_count;
        if (s4_rd_last) begin
          s4_tot = s4_rd_total;
          s4_sat_seen = s4_rd_sat;
          break;
        end
      end
    end
    check_eq("w4_sym7", s4_cnt[7], 15);
    check_eq("w4_sym1", s4_cnt[1], 0);
    check_eq("w4_total", s4_tot, 15);
    check_eq("w4_sat", s4_sat_seen, 1);
    step();

    // Restart inside accumulation, then done with a same-cycle increment
    drive(1'b1, 1'b0, 2, 6, 2);
    repeat (3) drive(1'b0, 1'b0, 2, 2, 6);
    drive(1'b1, 1'b0, 2, 2, 2);
    drive(1'b0, 1'b1, 1, 4, 0);
    wait_drain_empty();
    check_eq("restart_sym2", seen_cnt[2], 2);
    check_eq("restart_sym6", seen_cnt[6], 0);
    check_eq("done_inc_sym4", seen_cnt[4], 1);
    check_eq("restart_total", seen_total, 3);

    // Address 0 and a disabled lane
    drive(1'b1, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 1, 0, 9);
    drive(1'b0, 1'b0, 2, 9, 0);
    drive(1'b0, 1'b1, 0, 0, 0);
    wait_drain_empty();
    check_eq("addr0_sym9", seen_cnt[9], 1);
    check_eq("addr0_total", seen_total, 1);

    // Overlap: block B finishes while A drains under 50% backpressure
    drive(1'b1, 1'b0, 2, $urandom_range(DEPTH, 1), $urandom_range(DEPTH, 1));
    rand_incs(8);
    drive(1'b0, 1'b1, 0, 0, 0);
    rdy_pct = 50;
    wait_fill_ready();
    drive(1'b1, 1'b0, 2, $urandom_range(DEPTH, 0), $urandom_range(DEPTH, 0));
    rand_incs(6);
    drive(1'b0, 1'b1, 2, 1, 1);
    @(negedge clk);
    check_eq("overlap_fill_ready", fill_ready, 0);
    gap_armed = 1'b1;
    wait_drain_empty();
    check_eq("overlap_gap_seen", gap_armed, 0);

    // Random blocks with occasional restarts
    rdy_pct = 70;
    for (int b = 0; b < 6; b++) begin
      wait_fill_ready();
      drive(1'b1, 1'b0, $urandom_range(2, 0), $urandom_range(DEPTH, 0), $urandom_range(DEPTH, 0));
      for (int k = $urandom_range(20, 1); k > 0; k--) begin
        if ($urandom_range(9, 0) == 0)
          drive(1'b1, 1'b0, $urandom_range(2, 0), $urandom_range(DEPTH, 0), $urandom_range(DEPTH, 0));
        else
          rand_incs(1);
      end
      drive(1'b0, 1'b1, $urandom_range(2, 0), $urandom_range(DEPTH, 0), $urandom_range(DEPTH, 0));
    end
    wait_drain_empty();

    // Reset mid-drain and mid-accumulation
    rdy_pct = 100;
    drive(1'b1, 1'b0, 2, 4, 8);
    rand_incs(4);
    drive(1'b0, 1'b1, 0, 0, 0);
    repeat (5) step();
    drive(1'b1, 1'b0, 2, 3, 3);
    rand_incs(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_acc = 1'b0;
    model_clear();
    @(negedge clk);
    check_eq("midrst_rd_valid", rd_valid, 0);
    check_eq("midrst_fill_ready", fill_ready, 1);
    check_eq("midrst_rd_total", rd_total, 0);
    check_eq("midrst_rd_sym", rd_sym, 1);
    step();
    drive(1'b1, 1'b0, 1, 1, 0);
    drive(1'b0, 1'b1, 0, 0, 0);
    wait_drain_empty();
    check_eq("post_rst_sym1", seen_cnt[1], 1);
    check_eq("post_rst_sym3", seen_cnt[3], 0);
    check_eq("post_rst_total", seen_total, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
